// File: rtl/csa_pkg.sv
// Sizing helpers for the carry-save compressor tree: how many 3:2 levels a given
// operand count needs and how many vectors survive at each level.
package csa_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << r) < 64'(v)) begin
                r++;
            end
        end
        return r;
    endfunction

    // Every full group of three becomes two; leftovers pass through untouched.
    function automatic int unsigned next_count(input int unsigned v);
        return 2 * (v / 3) + (v % 3);
    endfunction

    function automatic int unsigned count_at(input int unsigned n, input int unsigned lvl);
        int unsigned v;
        v = n;
        for (int unsigned i = 0; i < lvl; i++) begin
            v = next_count(v);
        end
        return v;
    endfunction

    function automatic int unsigned num_levels(input int unsigned n);
        int unsigned v;
        int unsigned lv;
        v  = n;
        lv = 0;
        for (int i = 0; i < 256; i++) begin
            if (v > 2) begin
                v = next_count(v);
                lv++;
            end
        end
        return lv;
    endfunction

endpackage

// File: rtl/csa_3to2.sv
// Single 3:2 carry-save compressor; the carry output is already weighted by two.
module csa_3to2 #(
    parameter int unsigned Width = 8
) (
    input  logic [Width-1:0] x,
    input  logic [Width-1:0] y,
    input  logic [Width-1:0] z,
    output logic [Width-1:0] s,
    output logic [Width-1:0] c
);

    logic [Width-1:0] maj;

    assign s   = x ^ y ^ z;
    assign maj = (x & y) | (x & z) | (y & z);
    // Top majority bit falls off; the extension width guarantees it is zero.
    assign c   = maj << 1;

endmodule

// File: rtl/carry_save_adder.sv
// Reduces N unsigned W-bit operands to a registered redundant (sum, cout) pair
// through a purely combinational tree of 3:2 compressors.
module carry_save_adder
    import csa_pkg::*;
#(
    parameter int unsigned N = 256,
    parameter int unsigned E = 8,
    parameter int unsigned W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W*N-1:0]   a,
    output logic [W+E-1:0]   sum,
    output logic [W+E-1:0]   cout
);

    localparam int unsigned Vw     = W + E;
    localparam int unsigned Levels = num_levels(N);

    if (N < 3) begin : g_bad_n
        $error("carry_save_adder: N must be at least 3");
    end
    if (E < clog2(N)) begin : g_bad_e
        $error("carry_save_adder: E too small to hold the sum of N operands");
    end

    // vec[l][j] is vector j entering level l; slots beyond the live count are tied to zero.
    logic [Vw-1:0] vec [Levels+1][N];

    for (genvar k = 0; k < N; k++) begin : g_in
        assign vec[0][k] = Vw'(a[k*W +: W]);
    end

    for (genvar l = 0; l < Levels; l++) begin : g_level
        localparam int unsigned Cnt     = count_at(N, l);
        localparam int unsigned Grp     = Cnt / 3;
        localparam int unsigned NextCnt = next_count(Cnt);

        for (genvar g = 0; g < N / 3; g++) begin : g_csa
            if (g < Grp) begin : g_inst
                csa_3to2 #(
                    .Width(Vw)
                ) u_csa (
                    .x(vec[l][3*g]),
                    .y(vec[l][3*g+1]),
                    .z(vec[l][3*g+2]),
                    .s(vec[l+1][2*g]),
                    .c(vec[l+1][2*g+1])
                );
            end
        end

        for (genvar j = 0; j < N; j++) begin : g_fill
            if (j >= 2 * Grp && j < NextCnt) begin : g_pass
                assign vec[l+1][j] = vec[l][j+Grp];
            end else if (j >= NextCnt) begin : g_zero
                assign vec[l+1][j] = '0;
            end
        end
    end

    logic [Vw-1:0] sum_d, sum_q;
    logic [Vw-1:0] cout_d, cout_q;

    always_comb begin
        sum_d  = vec[Levels][0];
        cout_d = vec[Levels][1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= '0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_carry_save_adder.sv
// Bench for carry_save_adder: a default-sized instance and a small N=4, W=4, E=2 one,
// both checked against a plain operand-summing reference.
module tb_carry_save_adder;

    localparam int unsigned NB = 256;
    localparam int unsigned WB = 4;
    localparam int unsigned EB = 8;
    localparam int unsigned NS = 4;
    localparam int unsigned WS = 4;
    localparam int unsigned ES = 2;

    logic                 clk;
    logic                 rst;
    logic [WB*NB-1:0]     a_big;
    logic [WB+EB-1:0]     sum_big, cout_big;
    logic [WS*NS-1:0]     a_sml;
    logic [WS+ES-1:0]     sum_sml, cout_sml;

    int n_cmp;
    int n_err;

    carry_save_adder #(
        .N(NB),
        .E(EB),
        .W(WB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .a   (a_big),
        .sum (sum_big),
        .cout(cout_big)
    );

    carry_save_adder #(
        .N(NS),
        .E(ES),
        .W(WS)
    ) dut_sml (
        .clk (clk),
        .rst (rst),
        .a   (a_sml),
        .sum (sum_sml),
        .cout(cout_sml)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_big(input logic [WB*NB-1:0] v);
        int s;
        s = 0;
        for (int k = 0; k < int'(NB); k++) s += int'(v[k*WB +: WB]);
        return s;
    endfunction

    function automatic int ref_sml(input logic [WS*NS-1:0] v);
        int s;
        s = 0;
        for (int k = 0; k < int'(NS); k++) s += int'(v[k*WS +: WS]);
        return s;
    endfunction

    function automatic int tot_big();
        return int'(sum_big) + int'(cout_big);
    endfunction

    function automatic int tot_sml();
        return int'(sum_sml) + int'(cout_sml);
    endfunction

    function automatic logic [WB*NB-1:0] rand_big();
        logic [WB*NB-1:0] v;
        for (int i = 0; i < int'(WB*NB/32); i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (sum_big !== '0 || cout_big !== '0) begin
            n_err++;
            $display("FAIL reset_big: sum=%0d cout=%0d, want 0/0", sum_big, cout_big);
        end
        n_cmp++;
        if (sum_sml !== '0 || cout_sml !== '0) begin
            n_err++;
            $display("FAIL reset_sml: sum=%0d cout=%0d, want 0/0", sum_sml, cout_sml);
        end
    endtask

    task automatic test_zero();
        a_big = '0;
        a_sml = '0;
        step();
        n_cmp++;
        if (sum_big !== '0 || cout_big !== '0) begin
            n_err++;
            $display("FAIL zero_big: sum=%0d cout=%0d, want 0/0", sum_big, cout_big);
        end
        n_cmp++;
        if (sum_sml !== '0 || cout_sml !== '0) begin
            n_err++;
            $display("FAIL zero_sml: sum=%0d cout=%0d, want 0/0", sum_sml, cout_sml);
        end
    endtask

    task automatic test_small_vectors();
        logic [15:0] vecs [3];
        int          want [3];
        // operand 0 in the low nibble
        vecs[0] = {4'd0, 4'd0, 4'd10, 4'd10};  want[0] = 20;
        vecs[1] = {4'd15, 4'd15, 4'd15, 4'd15}; want[1] = 60;
        vecs[2] = {4'd7, 4'd4, 4'd2, 4'd11};    want[2] = 24;
        for (int i = 0; i < 3; i++) begin
            a_sml = vecs[i];
            step();
            n_cmp++;
            if (tot_sml() !== want[i] || tot_sml() >= 64) begin
                n_err++;
                $display("FAIL small_vec%0d: sum+cout=%0d, want %0d", i, tot_sml(), want[i]);
            end
        end
    endtask

    task automatic test_all_ones();
        a_big = '1;
        step();
        n_cmp++;
        if (tot_big() !== 3840) begin
            n_err++;
            $display("FAIL all_ones: sum+cout=%0d, want 3840", tot_big());
        end
        n_cmp++;
        if (tot_big() >= 4096) begin
            n_err++;
            $display("FAIL all_ones_width: sum+cout=%0d, want < 4096", tot_big());
        end
    endtask

    task automatic test_pattern_ec();
        a_big = {128{8'hEC}};
        step();
        n_cmp++;
        if (tot_big() !== 3328) begin
            n_err++;
            $display("FAIL pattern_ec: sum+cout=%0d, want 3328", tot_big());
        end
    endtask

    task automatic test_random();
        int want_b, want_s;
        for (int i = 0; i < 200; i++) begin
            a_big  = rand_big();
            a_sml  = 16'($urandom);
            want_b = ref_big(a_big);
            want_s = ref_sml(a_sml);
            step();
            n_cmp++;
            if (tot_big() !== want_b) begin
                n_err++;
                $display("FAIL random_big[%0d]: sum+cout=%0d, want %0d", i, tot_big(), want_b);
            end
            n_cmp++;
            if (tot_sml() !== want_s) begin
                n_err++;
                $display("FAIL random_sml[%0d]: sum+cout=%0d, want %0d", i, tot_sml(), want_s);
            end
        end
    endtask

    task automatic test_back_to_back();
        int prev, want;
        a_big = rand_big();
        step();
        prev = ref_big(a_big);
        for (int i = 0; i < 3000; i++) begin
            a_big = {a_big[WB*NB-2:0], a_big[WB*NB-1] ^ a_big[WB*NB-2]};
            want  = ref_big(a_big);
            // Between edges the outputs must still hold the previous result.
            #2;
            n_cmp++;
            if (tot_big() !== prev) begin
                n_err++;
                $display("FAIL b2b_hold[%0d]: sum+cout=%0d, want %0d", i, tot_big(), prev);
            end
            step();
            n_cmp++;
            if (tot_big() !== want) begin
                n_err++;
                $display("FAIL b2b[%0d]: sum+cout=%0d, want %0d", i, tot_big(), want);
            end
            prev = want;
        end
    endtask

    task automatic test_mid_reset();
        int want;
        a_big = {128{8'h5A}};
        step();
        n_cmp++;
        if (tot_big() !== ref_big(a_big)) begin
            n_err++;
            $display("FAIL pre_reset: sum+cout=%0d, want %0d", tot_big(), ref_big(a_big));
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (sum_big !== '0 || cout_big !== '0 || sum_sml !== '0 || cout_sml !== '0) begin
            n_err++;
            $display("FAIL async_reset: sum=%0d cout=%0d, want 0/0", sum_big, cout_big);
        end
        a_big = rand_big();
        step();
        step();
        n_cmp++;
        if (sum_big !== '0 || cout_big !== '0) begin
            n_err++;
            $display("FAIL held_reset: sum=%0d cout=%0d, want 0/0", sum_big, cout_big);
        end
        rst   = 1'b0;
        a_big = rand_big();
        want  = ref_big(a_big);
        step();
        n_cmp++;
        if (tot_big() !== want) begin
            n_err++;
            $display("FAIL post_reset: sum+cout=%0d, want %0d", tot_big(), want);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        a_big = rand_big();
        a_sml = 16'hFFFF;
        #3;
        test_reset();
        step();
        step();
        test_reset();
        rst = 1'b0;
        test_zero();
        test_small_vectors();
        test_all_ones();
        test_pattern_ec();
        test_random();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
